// File: rtl/csel_adder_pipe.sv
// Two-stage pipelined carry-select adder/subtractor with valid/ready on both sides.
// Stage 1 registers both per-block candidate sums; stage 2 resolves the select chain.
module csel_adder_pipe #(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NBLK = (BLOCK > 0) ? WIDTH / BLOCK : 1;

  generate
    if (BLOCK < 1 || WIDTH < 1 || (WIDTH % BLOCK) != 0) begin : g_bad_params
      $error("csel_adder_pipe: WIDTH must be a positive multiple of BLOCK");
    end
  endgenerate

  logic [WIDTH-1:0] beff;
  logic             ceff;

  assign beff = b ^ {WIDTH{sub}};
  assign ceff = sub | cin;

  logic [BLOCK:0] cand0_next [NBLK];
  logic [BLOCK:0] cand1_next [NBLK];
  logic [BLOCK:0] cand0_reg  [NBLK];
  logic [BLOCK:0] cand1_reg  [NBLK];
  logic           ceff_reg;
  logic           a_msb_reg;
  logic           b_msb_reg;
  logic           s1_v;
  logic           s2_v;
  logic           s1_en;
  logic           s2_en;

  // Both candidates per block come from the same operand slice; only carry-in differs.
  generate
    for (genvar gi = 0; gi < NBLK; gi++) begin : g_blk
      assign cand0_next[gi] = {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, beff[gi*BLOCK +: BLOCK]};
      assign cand1_next[gi] = {1'b0, a[gi*BLOCK +: BLOCK]} + {1'b0, beff[gi*BLOCK +: BLOCK]}
                              + {{BLOCK{1'b0}}, 1'b1};
    end
  endgenerate

  assign s2_en     = ~s2_v | out_ready;
  assign s1_en     = ~s1_v | s2_en;
  assign in_ready  = s1_en;
  assign out_valid = s2_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v      <= 1'b0;
      ceff_reg  <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      for (int k = 0; k < NBLK; k++) begin
        cand0_reg[k] <= '0;
        cand1_reg[k] <= '0;
      end
    end else if (s1_en) begin
      s1_v <= in_valid;
      if (in_valid) begin
        ceff_reg  <= ceff;
        a_msb_reg <= a[WIDTH-1];
        b_msb_reg <= beff[WIDTH-1];
        for (int k = 0; k < NBLK; k++) begin
          cand0_reg[k] <= cand0_next[k];
          cand1_reg[k] <= cand1_next[k];
        end
      end
    end
  end

  logic [WIDTH-1:0] sum_next;
  logic             carry_next;
  logic [BLOCK:0]   pick;
  logic             ovf_next;
  logic             zero_next;

  // Ripple the block select from ceff up through the registered candidates.
  always_comb begin
    sum_next   = '0;
    carry_next = ceff_reg;
    pick       = '0;
    for (int k = 0; k < NBLK; k++) begin
      pick = carry_next ? cand1_reg[k] : cand0_reg[k];
      sum_next[k*BLOCK +: BLOCK] = pick[BLOCK-1:0];
      carry_next = pick[BLOCK];
    end
  end

  assign ovf_next  = (a_msb_reg == b_msb_reg) & (sum_next[WIDTH-1] != a_msb_reg);
  assign zero_next = ~|sum_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
      zero <= 1'b0;
    end else begin
      if (s2_en) begin
        s2_v <= s1_v;
      end
      if (s2_en && s1_v) begin
        sum  <= sum_next;
        cout <= carry_next;
        ovf  <= ovf_next;
        zero <= zero_next;
      end
    end
  end

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed and streaming bench for csel_adder_pipe at 32/8, 16/4 and 12/12.
// Expected values come from hand-computed tables or an arithmetic reference model.
module tb_csel_adder_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        in_valid = 1'b0, cin = 1'b0, sub = 1'b0, out_ready = 1'b1;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, cout, ovf, zero;
  logic [31:0] sum;

  logic        sv = 1'b0, s_cin = 1'b0, s_sub = 1'b0;
  logic [31:0] sa = '0, sb = '0;
  logic        ir16, ov16, c16, f16, z16;
  logic [15:0] s16;
  logic        ir12, ov12, c12, f12, z12;
  logic [11:0] s12;

  csel_adder_pipe #(.WIDTH(32), .BLOCK(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .zero(zero)
  );

  csel_adder_pipe #(.WIDTH(16), .BLOCK(4)) dut16 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(ir16),
    .a(sa[15:0]), .b(sb[15:0]), .cin(s_cin), .sub(s_sub), .out_valid(ov16), .out_ready(1'b1),
    .sum(s16), .cout(c16), .ovf(f16), .zero(z16)
  );

  csel_adder_pipe #(.WIDTH(12), .BLOCK(12)) dut12 (
    .clk(clk), .rst(rst), .in_valid(sv), .in_ready(ir12),
    .a(sa[11:0]), .b(sb[11:0]), .cin(s_cin), .sub(s_sub), .out_valid(ov12), .out_ready(1'b1),
    .sum(s12), .cout(c12), .ovf(f12), .zero(z12)
  );

  // Reference: returns {ovf, zero, cout, sum} using wide signed/unsigned arithmetic.
  function automatic logic [34:0] gold(input int w, input logic [31:0] x, input logic [31:0] y,
                                       input logic ci, input logic sb_);
    longint mask, ux, uy, tot, sx, sy, res, lim, lci;
    logic [31:0] s;
    logic c, v;
    mask = (longint'(1) << w) - 1;
    ux = {32'b0, x} & mask;
    uy = {32'b0, y} & mask;
    lci = {63'b0, ci};
    if (sb_) begin
      c = (ux >= uy);
      tot = ux - uy;
    end else begin
      tot = ux + uy + lci;
      c = tot[w];
    end
    s = 32'(tot & mask);
    sx = ux[w-1] ? ux - (longint'(1) << w) : ux;
    sy = uy[w-1] ? uy - (longint'(1) << w) : uy;
    res = sb_ ? sx - sy : sx + sy + lci;
    lim = longint'(1) << (w - 1);
    v = (res >= lim) || (res < -lim);
    return {v, (s == 32'd0), c, s};
  endfunction

  task automatic drive_rand;
    in_valid = 1'b1;
    a = $urandom();
    b = $urandom();
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask

  task automatic test_reset;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({out_valid, sum, cout, ovf, zero} !== 36'h0) begin
      errors++;
      $display("FAIL reset_state got=%h want=0", {out_valid, sum, cout, ovf, zero});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL reset_release in_ready/out_valid got=%b want=10", {in_ready, out_valid});
    end
  endtask

  task automatic test_directed;
    logic [31:0] va [8] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h5, 32'hFF, 32'h00FFFFFF, 32'hA, 32'h80000000, 32'h5};
    logic [31:0] vb [8] = '{32'h1, 32'h1, 32'h7, 32'h0, 32'h0, 32'h3, 32'h1, 32'h5};
    logic        vc [8] = '{0, 0, 0, 1, 1, 1, 0, 0};
    logic        vs [8] = '{0, 0, 1, 0, 0, 1, 1, 1};
    logic [31:0] es [8] = '{32'h0, 32'h80000000, 32'hFFFFFFFE, 32'h100, 32'h01000000, 32'h7, 32'h7FFFFFFF, 32'h0};
    logic        ec [8] = '{1, 0, 0, 0, 0, 1, 1, 1};
    logic        eo [8] = '{0, 1, 0, 0, 0, 0, 1, 0};
    logic        ez [8] = '{1, 0, 0, 0, 0, 0, 0, 1};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      a = va[i]; b = vb[i]; cin = vc[i]; sub = vs[i];
      in_valid = 1'b1;
      out_ready = 1'b1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_in_ready got=%b want=1", i, in_ready);
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL dir%0d_latency_early out_valid got=%b want=0", i, out_valid);
      end
      @(negedge clk);
      checks++;
      if (out_valid !== 1'b1) begin
        errors++;
        $display("FAIL dir%0d_latency out_valid got=%b want=1", i, out_valid);
      end
      checks++;
      if ({ovf, zero, cout, sum} !== {eo[i], ez[i], ec[i], es[i]}) begin
        errors++;
        $display("FAIL dir%0d_result got ovf=%b zero=%b cout=%b sum=%h want ovf=%b zero=%b cout=%b sum=%h",
                 i, ovf, zero, cout, sum, eo[i], ez[i], ec[i], es[i]);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [34:0] exp_q [$];
    logic [34:0] e;
    int sent = 0, got = 0, first = -1, last = -1, blocked = 0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive_rand();
    for (int cyc = 0; cyc < 60 && got < 16; cyc++) begin
      @(negedge clk);
      if (in_valid && in_ready) begin
        exp_q.push_back(gold(32, a, b, cin, sub));
        sent++;
      end else if (in_valid) begin
        blocked++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL b2b_extra_beat got sum=%h want none", sum);
        end else begin
          e = exp_q.pop_front();
          if ({ovf, zero, cout, sum} !== e) begin
            errors++;
            $display("FAIL b2b_beat%0d got=%h want=%h", got, {ovf, zero, cout, sum}, e);
          end
        end
        if (first < 0) first = cyc;
        last = cyc;
        got++;
      end
      @(posedge clk); #1;
      if (sent < 16) drive_rand();
      else in_valid = 1'b0;
    end
    checks++;
    if (got != 16) begin
      errors++;
      $display("FAIL b2b_count got=%0d want=16", got);
    end
    checks++;
    if (last - first != 15 || blocked != 0) begin
      errors++;
      $display("FAIL b2b_rate span got=%0d want=15 blocked got=%0d want=0", last - first, blocked);
    end
  endtask

  task automatic test_stall;
    logic [34:0] exp_q [$];
    logic [34:0] e, snap;
    int sent = 0, got = 0;
    snap = '0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    drive_rand();
    for (int cyc = 0; cyc < 80 && got < 10; cyc++) begin
      @(negedge clk);
      if (cyc >= 4 && cyc < 8) begin
        checks++;
        if ({in_ready, out_valid} !== 2'b01) begin
          errors++;
          $display("FAIL stall_c%0d in_ready/out_valid got=%b want=01", cyc, {in_ready, out_valid});
        end
        if (cyc == 4) begin
          snap = {ovf, zero, cout, sum};
        end else begin
          checks++;
          if ({ovf, zero, cout, sum} !== snap) begin
            errors++;
            $display("FAIL stall_hold_c%0d got=%h want=%h", cyc, {ovf, zero, cout, sum}, snap);
          end
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(gold(32, a, b, cin, sub));
        sent++;
      end
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL stall_extra_beat got sum=%h want none", sum);
        end else begin
          e = exp_q.pop_front();
          if ({ovf, zero, cout, sum} !== e) begin
            errors++;
            $display("FAIL stall_beat%0d got=%h want=%h", got, {ovf, zero, cout, sum}, e);
          end
        end
        got++;
      end
      @(posedge clk); #1;
      out_ready = !((cyc + 1) >= 4 && (cyc + 1) < 8);
      if (sent < 10) drive_rand();
      else in_valid = 1'b0;
    end
    checks++;
    if (got != 10 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL stall_count got=%0d pending=%0d want=10 pending=0", got, exp_q.size());
    end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL stall_no_dup out_valid got=%b want=0", out_valid);
    end
  endtask

  task automatic test_reset_in_flight;
    int stray = 0;
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'h1; b = 32'h2; cin = 1'b0; sub = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    a = 32'h3; b = 32'h4;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid, sum} !== {1'b1, 32'h3}) begin
      errors++;
      $display("FAIL rstfl_pre got valid=%b sum=%h want valid=1 sum=00000003", out_valid, sum);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({out_valid, sum, cout, ovf, zero} !== 36'h0) begin
      errors++;
      $display("FAIL rstfl_clear got=%h want=0", {out_valid, sum, cout, ovf, zero});
    end
    @(posedge clk); #2;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL rstfl_flushed stray_cycles got=%0d want=0", stray);
    end
    @(posedge clk); #1;
    in_valid = 1'b1; a = 32'h12345678; b = 32'h11111111; cin = 1'b1; sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rstfl_early out_valid got=%b want=0", out_valid);
    end
    @(negedge clk);
    checks++;
    if ({out_valid, ovf, zero, cout, sum} !== {4'b1000, 32'h2345678A}) begin
      errors++;
      $display("FAIL rstfl_new_beat got valid=%b ovf=%b zero=%b cout=%b sum=%h want 1 0 0 0 2345678a",
               out_valid, ovf, zero, cout, sum);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_small_widths;
    logic [65:0] in_q [$];
    logic [65:0] t;
    logic [34:0] e16, e12;
    logic [31:0] da [4] = '{32'h00FF, 32'h7FFF, 32'h5, 32'hFFFF};
    logic [31:0] db [4] = '{32'h0, 32'h1, 32'h7, 32'h1};
    logic        dc [4] = '{1, 0, 0, 0};
    logic        ds [4] = '{0, 0, 1, 0};
    int sent = 0, got = 0;
    for (int cyc = 0; cyc < 80 && got < 20; cyc++) begin
      @(posedge clk); #1;
      if (sent < 4) begin
        sv = 1'b1; sa = da[sent]; sb = db[sent]; s_cin = dc[sent]; s_sub = ds[sent];
      end else if (sent < 20) begin
        sv = 1'b1; sa = $urandom(); sb = $urandom();
        s_cin = 1'($urandom_range(0, 1)); s_sub = 1'($urandom_range(0, 1));
      end else begin
        sv = 1'b0;
      end
      @(negedge clk);
      if (sv && ir16 && ir12) begin
        in_q.push_back({s_sub, s_cin, sa, sb});
        sent++;
      end
      if (ov16 || ov12) begin
        checks++;
        if (in_q.size() == 0 || ov16 !== ov12) begin
          errors++;
          $display("FAIL small_valid got v16=%b v12=%b pending=%0d want both with pending>0",
                   ov16, ov12, in_q.size());
        end else begin
          t = in_q.pop_front();
          e16 = gold(16, t[63:32], t[31:0], t[64], t[65]);
          e12 = gold(12, t[63:32], t[31:0], t[64], t[65]);
          if ({f16, z16, c16, 16'h0, s16} !== e16) begin
            errors++;
            $display("FAIL w16_beat%0d got=%h want=%h", got, {f16, z16, c16, 16'h0, s16}, e16);
          end
          checks++;
          if ({f12, z12, c12, 20'h0, s12} !== e12) begin
            errors++;
            $display("FAIL w12_beat%0d got=%h want=%h", got, {f12, z12, c12, 20'h0, s12}, e12);
          end
        end
        got++;
      end
    end
    sv = 1'b0;
    checks++;
    if (got != 20) begin
      errors++;
      $display("FAIL small_count got=%0d want=20", got);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall();
    test_reset_in_flight();
    test_small_widths();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
